uart_rx_fifo: RTL and testbench

//   Downstream consumer of the UART receiver. Brings the receiver's RxDone/RxError
//     (driven from the slow RecClock domain) into the system Clock domain.

---
 rtl/uart_rx_fifo_if.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : Bundles the receiver-side inputs and the host read/status port
//            of uart_rx_fifo.
// Ports    : slave  - the FIFO side (consumes RxData/RxDone/RxError/RdEn/
//                     ClearFlags, drives RdData/RdValid and status)
//            master - the driver side (receiver model plus host)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int ADDR_W   = 4,
  parameter int ERRCNT_W = 8
);
  logic [7:0]          RxData;
  logic                RxDone;
  logic                RxError;
  logic                RdEn;
  logic                ClearFlags;
  logic [7:0]          RdData;
  logic                RdValid;
  logic                Empty;
  logic                Full;
  logic [ADDR_W:0]     Count;
  logic                Overflow;
  logic                Underflow;
  logic                ErrFlag;
  logic [ERRCNT_W-1:0] ErrCnt;

  modport slave (
    input  RxData, RxDone, RxError, RdEn, ClearFlags,
    output RdData, RdValid, Empty, Full, Count,
           Overflow, Underflow, ErrFlag, ErrCnt
  );

  modport master (
    output RxData, RxDone, RxError, RdEn, ClearFlags,
    input  RdData, RdValid, Empty, Full, Count,
           Overflow, Underflow, ErrFlag, ErrCnt
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receives completed UART bytes from the RecClock domain,
//            synchronises RxDone/RxError into Clock, stores bytes in a
//            2**ADDR_W entry FIFO and presents a registered read port with
//            occupancy, sticky error flags and a saturating error counter.
// Ports    : Clock - system clock
//            Reset - asynchronous, active-low reset
//            bus   - uart_rx_fifo_if.slave (RxData, RxDone, RxError, RdEn,
//                    ClearFlags in; RdData, RdValid, Empty, Full, Count,
//                    Overflow, Underflow, ErrFlag, ErrCnt out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int ADDR_W   = 4,
  parameter int ERRCNT_W = 8
) (
  input  wire logic          Clock,
  input  wire logic          Reset,
  uart_rx_fifo_if.slave      bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_depthCount = (ADDR_W + 1)'(DEPTH);

  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wrPtr;
  logic [ADDR_W-1:0]   r_rdPtr;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_rdData;
  logic                r_rdValid;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_errFlag;
  logic [ERRCNT_W-1:0] r_errCnt;
  logic                r_d1, r_d2, r_d3;
  logic                r_e1, r_e2, r_e3;
  logic [1:0]          r_armCnt;

  logic w_armed;
  logic w_push;
  logic w_errEvt;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_write;

  // Edges seen before the synchroniser has filled with post-reset samples
  // are ignored, so a level already high at release is never captured.
  assign w_armed  = &r_armCnt;
  assign w_push   = w_armed & r_d2 & ~r_d3;
  assign w_errEvt = w_armed & r_e2 & ~r_e3;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_depthCount);
  // No fall-through: a read against an empty FIFO is refused even if a
  // byte is being written in the same cycle.
  assign w_pop    = bus.RdEn & ~w_empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_write  = w_push & (~w_full | w_pop);

  // Storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge Clock) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= bus.RxData;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_d3        <= 1'b0;
      r_e1        <= 1'b0;
      r_e2        <= 1'b0;
      r_e3        <= 1'b0;
      r_armCnt    <= 2'd0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_rdData    <= 8'h00;
      r_rdValid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_errFlag   <= 1'b0;
      r_errCnt    <= '0;
    end else begin
      r_d1 <= bus.RxDone;
      r_d2 <= r_d1;
      r_d3 <= r_d2;
      r_e1 <= bus.RxError;
      r_e2 <= r_e1;
      r_e3 <= r_e2;

      if (r_armCnt != 2'd3) begin
        r_armCnt <= r_armCnt + 2'd1;
      end

      if (w_write) begin
        r_wrPtr <= r_wrPtr + ADDR_W'(1);
      end

      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + ADDR_W'(1);
        r_rdData <= r_mem[r_rdPtr];
      end
      r_rdValid <= w_pop;

      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase

      // Set events take priority over ClearFlags in the same cycle.
      if (w_push & ~w_write) begin
        r_overflow <= 1'b1;
      end else if (bus.ClearFlags) begin
        r_overflow <= 1'b0;
      end

      if (bus.RdEn & w_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.ClearFlags) begin
        r_underflow <= 1'b0;
      end

      if (w_errEvt) begin
        r_errFlag <= 1'b1;
        if (bus.ClearFlags) begin
          r_errCnt <= ERRCNT_W'(1);
        end else if (r_errCnt != '1) begin
          r_errCnt <= r_errCnt + ERRCNT_W'(1);
        end
      end else if (bus.ClearFlags) begin
        r_errFlag <= 1'b0;
        r_errCnt  <= '0;
      end
    end
  end

  assign bus.RdData    = r_rdData;
  assign bus.RdValid   = r_rdValid;
  assign bus.Empty     = w_empty;
  assign bus.Full      = w_full;
  assign bus.Count     = r_count;
  assign bus.Overflow  = r_overflow;
  assign bus.Underflow = r_underflow;
  assign bus.ErrFlag   = r_errFlag;
  assign bus.ErrCnt    = r_errCnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. Expected read bytes are
//            queued as frames are driven and compared as RdValid strobes.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int ADDR_W   = 4;
  localparam int ERRCNT_W = 8;
  localparam int DEPTH    = 2 ** ADDR_W;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) bus ();

  uart_rx_fifo #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int         nCompared   = 0;
  int         nMismatched = 0;
  logic [7:0] sbQ[$];
  logic [7:0] lastRead = 8'h00;
  int         errModel = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every read strobe must match the oldest queued byte.
  always @(negedge Clock) begin
    if (Reset && bus.RdValid) begin
      if (sbQ.size() > 0) begin
        checkVal("rd_data", {24'h0, bus.RdData}, {24'h0, sbQ.pop_front()});
      end else begin
        checkVal("rd_unexpected", 32'(sbQ.size()), 32'd1);
      end
      lastRead = bus.RdData;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One frame: RxDone held for 3 cycles then low for 3, so each frame
  // produces exactly one synchronised rising edge.
  task automatic sendByte(input logic [7:0] b);
    bus.RxData = b;
    bus.RxDone = 1'b1;
    if (sbQ.size() < DEPTH) sbQ.push_back(b);
    repeat (3) @(posedge Clock);
    #1 bus.RxDone = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic readN(input int n);
    bus.RdEn = 1'b1;
    repeat (n) @(posedge Clock);
    #1 bus.RdEn = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  task automatic pulseClear();
    bus.ClearFlags = 1'b1;
    @(posedge Clock);
    #1 bus.ClearFlags = 1'b0;
  endtask

  initial begin
    bus.RxData     = 8'h00;
    bus.RxDone     = 1'b0;
    bus.RxError    = 1'b0;
    bus.RdEn       = 1'b0;
    bus.ClearFlags = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checkVal("rst_count",   32'(bus.Count), 32'd0);
    checkVal("rst_empty",   32'(bus.Empty), 32'd1);
    checkVal("rst_full",    32'(bus.Full), 32'd0);
    checkVal("rst_rddata",  32'(bus.RdData), 32'd0);
    checkVal("rst_rdvalid", 32'(bus.RdValid), 32'd0);
    checkVal("rst_flags",   {28'h0, bus.Overflow, bus.Underflow, bus.ErrFlag, 1'b0}, 32'd0);
    checkVal("rst_errcnt",  32'(bus.ErrCnt), 32'd0);
    Reset = 1'b1;
    repeat (4) @(posedge Clock);
    #1;

    // 1: capture latency, long RxDone level gives one push, single read.
    bus.RxData = 8'hA5;
    bus.RxDone = 1'b1;
    @(posedge Clock); #1 checkVal("t1_cnt_n",  32'(bus.Count), 32'd0);
    @(posedge Clock); #1 checkVal("t1_cnt_n1", 32'(bus.Count), 32'd0);
    @(posedge Clock); #1 checkVal("t1_cnt_n2", 32'(bus.Count), 32'd1);
    sbQ.push_back(8'hA5);
    repeat (17) @(posedge Clock);
    #1 bus.RxDone = 1'b0;
    repeat (4) @(posedge Clock);
    #1 checkVal("t1_one_push", 32'(bus.Count), 32'd1);
    bus.RdEn = 1'b1;
    @(posedge Clock);
    #1 bus.RdEn = 1'b0;
    checkVal("t1_rdvalid", 32'(bus.RdValid), 32'd1);
    checkVal("t1_empty",   32'(bus.Empty), 32'd1);
    @(posedge Clock);
    #1 checkVal("t1_rdvalid_1cyc", 32'(bus.RdValid), 32'd0);

    // 2: fill to full, overflow drop, drain in order.
    for (int i = 0; i < DEPTH; i++) sendByte(8'(i));
    checkVal("t2_full",  32'(bus.Full), 32'd1);
    checkVal("t2_count", 32'(bus.Count), 32'd16);
    checkVal("t2_no_ovf", 32'(bus.Overflow), 32'd0);
    sendByte(8'hFF);
    checkVal("t2_ovf",       32'(bus.Overflow), 32'd1);
    checkVal("t2_count_ovf", 32'(bus.Count), 32'd16);
    readN(DEPTH);
    checkVal("t2_empty",    32'(bus.Empty), 32'd1);
    checkVal("t2_last",     32'(lastRead), 32'h0F);
    checkVal("t2_sb_drain", 32'(sbQ.size()), 32'd0);

    // 3: push coincident with pop on a full FIFO.
    pulseClear();
    #1 checkVal("t3_ovf_clr", 32'(bus.Overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) sendByte(8'(8'h10 + i));
    bus.RxData = 8'h77;
    bus.RxDone = 1'b1;
    sbQ.push_back(8'h77);
    @(posedge Clock);
    @(posedge Clock);
    #1 bus.RdEn = 1'b1;
    @(posedge Clock);
    #1 bus.RdEn = 1'b0;
    checkVal("t3_count", 32'(bus.Count), 32'd16);
    checkVal("t3_no_ovf", 32'(bus.Overflow), 32'd0);
    repeat (2) @(posedge Clock);
    #1 bus.RxDone = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    readN(DEPTH);
    checkVal("t3_last_new", 32'(lastRead), 32'h77);
    checkVal("t3_empty",    32'(bus.Empty), 32'd1);

    // 4: underflow, clear, clear coincident with an error edge.
    bus.RdEn = 1'b1;
    @(posedge Clock);
    #1 bus.RdEn = 1'b0;
    checkVal("t4_udf",     32'(bus.Underflow), 32'd1);
    checkVal("t4_rdvalid", 32'(bus.RdValid), 32'd0);
    checkVal("t4_rd_hold", 32'(bus.RdData), 32'h77);
    pulseClear();
    #1 checkVal("t4_udf_clr", 32'(bus.Underflow), 32'd0);
    bus.RxError = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1 bus.ClearFlags = 1'b1;
    @(posedge Clock);
    #1 bus.ClearFlags = 1'b0;
    errModel = 1;
    checkVal("t4_errflag", 32'(bus.ErrFlag), 32'd1);
    checkVal("t4_errcnt",  32'(bus.ErrCnt), 32'(errModel));
    repeat (2) @(posedge Clock);
    #1 bus.RxError = 1'b0;
    repeat (3) @(posedge Clock);
    #1;

    // 5: 300 error edges saturate the counter; no data is pushed.
    for (int i = 0; i < 300; i++) begin
      bus.RxError = 1'b1;
      repeat (3) @(posedge Clock);
      #1 bus.RxError = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      if (errModel < 255) errModel++;
      if (i == 99) checkVal("t5_errcnt_mid", 32'(bus.ErrCnt), 32'(errModel));
    end
    checkVal("t5_errcnt_sat", 32'(bus.ErrCnt), 32'hFF);
    checkVal("t5_errflag",    32'(bus.ErrFlag), 32'd1);
    checkVal("t5_count",      32'(bus.Count), 32'd0);
    pulseClear();
    #1 checkVal("t5_errcnt_clr", 32'(bus.ErrCnt), 32'd0);
    checkVal("t5_errflag_clr", 32'(bus.ErrFlag), 32'd0);

    // 6: RxDone high across reset release is ignored; async reset mid-stream.
    bus.RxDone = 1'b1;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    repeat (8) @(posedge Clock);
    #1 bus.RxDone = 1'b0;
    repeat (4) @(posedge Clock);
    #1 checkVal("t6_no_push", 32'(bus.Count), 32'd0);
    for (int i = 0; i < 5; i++) sendByte(8'(8'h30 + i));
    checkVal("t6_count5", 32'(bus.Count), 32'd5);
    bus.RxData = 8'h55;
    bus.RxDone = 1'b1;
    @(posedge Clock);
    #2 Reset = 1'b0;
    sbQ.delete();
    #1;
    checkVal("t6_async_count", 32'(bus.Count), 32'd0);
    checkVal("t6_async_empty", 32'(bus.Empty), 32'd1);
    bus.RxDone = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    repeat (6) @(posedge Clock);
    #1 checkVal("t6_post_count", 32'(bus.Count), 32'd0);
    checkVal("t6_sb_final", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
